// File: rtl/dct_pkg.sv
// Shared constants and FSM state type for the DCT pipe sequencer.
package dct_pkg;

    localparam int BLK_SIZE = 64;
    localparam int IDX_W    = 6;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

endpackage

// File: rtl/dct_occ_shift.sv
// ce-gated occupancy shift register; bit 0 is the entry stage.
module dct_occ_shift #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             din,
    output logic [DEPTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ce)
            q <= {q[DEPTH-2:0], din};
    end

endmodule

// File: rtl/dct_pipe_ctrl.sv
// Sequencer for the ce-gated DCT delay chain: occupancy tracking,
// valid/ready backpressure, 8x8 block framing and flush.
module dct_pipe_ctrl
    import dct_pkg::*;
#(
    parameter int PIPE_DEPTH = 8,
    parameter int BLK_SIZE   = dct_pkg::BLK_SIZE,
    parameter int IDX_W      = dct_pkg::IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sob,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  ce,
    output logic [PIPE_DEPTH-1:0] stage_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_sob,
    output logic                  out_eob,
    output logic                  blk_done,
    output logic                  err_sync,
    output logic                  flush_done,
    output logic                  busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(BLK_SIZE - 1);

    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] x);
        return (x == LAST) ? '0 : x + 1'b1;
    endfunction

    state_t                  state, state_nxt;
    logic [PIPE_DEPTH-1:0]   sob_pipe;
    logic [IDX_W-1:0]        in_cnt, out_cnt;
    logic                    accept, hs, pipe_empty, drain_done;

    // Fully stalling: every stage moves only when the tail can leave.
    assign ce         = !rst & (!out_valid | out_ready);
    assign in_ready   = ce & (state != DRAIN) & !flush;
    assign accept     = in_valid & in_ready;
    assign out_valid  = stage_valid[PIPE_DEPTH-1];
    assign hs         = out_valid & out_ready;
    assign pipe_empty = (stage_valid == '0);
    assign drain_done = (state == DRAIN) & pipe_empty;
    assign busy       = (state != IDLE);

    assign out_sob = out_valid & sob_pipe[PIPE_DEPTH-1];
    assign out_idx = out_sob ? '0 : out_cnt;
    assign out_eob = out_valid & (out_idx == LAST);

    dct_occ_shift #(.DEPTH(PIPE_DEPTH)) u_vld (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .din (accept),
        .q   (stage_valid)
    );

    dct_occ_shift #(.DEPTH(PIPE_DEPTH)) u_sob (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .din (in_sob & accept),
        .q   (sob_pipe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_cnt     <= '0;
            out_cnt    <= '0;
            err_sync   <= 1'b0;
            blk_done   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            err_sync   <= 1'b0;
            blk_done   <= hs & out_eob;
            flush_done <= drain_done;
            if (drain_done) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                // A misplaced sob restarts the block; a missing one only flags.
                if (accept) begin
                    if (in_sob) begin
                        err_sync <= (in_cnt != '0);
                        in_cnt   <= inc('0);
                    end else begin
                        err_sync <= (in_cnt == '0);
                        in_cnt   <= inc(in_cnt);
                    end
                end
                if (hs)
                    out_cnt <= inc(out_idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
                     else if (flush) state_nxt = DRAIN;
            RUN:     if (flush) state_nxt = DRAIN;
                     else if (pipe_empty && !accept) state_nxt = IDLE;
            DRAIN:   if (pipe_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dct_pipe_ctrl.sv
// Directed bench for dct_pipe_ctrl with a small sob/index scoreboard.
module tb_dct_pipe_ctrl;

    localparam int PD = 8;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_sob, in_ready, flush, ce;
    logic [PD-1:0] stage_valid;
    logic          out_valid, out_ready, out_sob, out_eob;
    logic [5:0]    out_idx;
    logic          blk_done, err_sync, flush_done, busy;

    dct_pipe_ctrl #(.PIPE_DEPTH(PD)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sob      (in_sob),
        .in_ready    (in_ready),
        .flush       (flush),
        .ce          (ce),
        .stage_valid (stage_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_sob     (out_sob),
        .out_eob     (out_eob),
        .blk_done    (blk_done),
        .err_sync    (err_sync),
        .flush_done  (flush_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int ocnt = 0, tin = 0, n_acc = 0, n_hs = 0;
    bit exp_err = 0, exp_blk = 0;
    bit sob_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Apply inputs, then score the cycle against the reference model.
    task automatic drive(input bit v, input bit sob, input bit fl, input bit ordy);
        bit s_q;
        int idx;
        in_valid = v; in_sob = sob; flush = fl; out_ready = ordy;
        #1;
        if (!rst) begin
            chk("err_sync", err_sync, exp_err);
            chk("blk_done", blk_done, exp_blk);
            exp_err = 0;
            exp_blk = 0;
            if (in_valid && in_ready) begin
                n_acc++;
                sob_q.push_back(in_sob);
                if (in_sob) begin
                    exp_err = (tin != 0);
                    tin = 1;
                end else begin
                    exp_err = (tin == 0);
                    tin = (tin + 1) % 64;
                end
            end
            if (out_valid && out_ready) begin
                n_hs++;
                if (sob_q.size() == 0) begin
                    chk("q_underflow", sob_q.size(), 1);
                end else begin
                    s_q = sob_q.pop_front();
                    idx = s_q ? 0 : ocnt;
                    chk("out_idx", out_idx, idx);
                    chk("out_sob", out_sob, (idx == 0));
                    chk("out_eob", out_eob, (idx == 63));
                    exp_blk = (idx == 63);
                    ocnt = (idx + 1) % 64;
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input bit sob, input bit fl, input bit ordy);
        drive(v, sob, fl, ordy);
        adv();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; in_valid = 0; in_sob = 0; flush = 0; out_ready = 1;
        drive(0, 0, 0, 1);
        chk("rst_ce", ce, 0);
        chk("rst_in_ready", in_ready, 0);
        adv();
        adv();
        rst = 0;
        #1;
        chk("rst_stage_valid", stage_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_out_idx", out_idx, 0);

        // 1: back-to-back block, latency PD
        for (int i = 0; i < 64; i++) begin
            drive(1, i == 0, 0, 1);
            chk("t1_latency", out_valid, (i >= PD));
            adv();
        end
        idle(12);
        chk("t1_idle", busy, 0);

        // 2: 5-cycle stall mid-block
        for (int i = 0; i < 20; i++) step(1, i == 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0);
            chk("t2_ce", ce, 0);
            chk("t2_in_ready", in_ready, 0);
            chk("t2_stage_valid", stage_valid, 8'hFF);
            adv();
        end
        for (int i = 20; i < 64; i++) step(1, 0, 0, 1);
        idle(12);

        // 3: sob at input index 10
        for (int i = 0; i < 16; i++) step(1, (i == 0) || (i == 10), 0, 1);
        idle(12);

        // 5: one-cycle flush with 3 samples in flight
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, i == 0, 1);
            chk("t5_in_ready", in_ready, 0);
            chk("t5_busy", busy, 1);
            chk("t5_fd_early", flush_done, 0);
            adv();
        end
        drive(0, 0, 0, 1);
        chk("t5_flush_done", flush_done, 1);
        chk("t5_busy_end", busy, 0);
        chk("t5_drained", sob_q.size(), 0);
        adv();
        tin = 0;
        ocnt = 0;

        // 4: alternating bubbles
        for (int i = 0; i < 16; i++) begin
            drive(i % 2 == 0, i == 0, 0, 1);
            if (i == 8) begin
                chk("t4_stage_valid", stage_valid, 8'hAA);
                chk("t4_out_valid", out_valid, 1);
            end
            adv();
        end
        idle(12);

        // 6: reset at sample 30, then a fresh block
        for (int i = 0; i < 30; i++) step(1, i == 0, 0, 1);
        rst = 1;
        drive(0, 0, 0, 1);
        chk("t6_ce", ce, 0);
        chk("t6_in_ready", in_ready, 0);
        adv();
        rst = 0;
        sob_q.delete();
        ocnt = 0; tin = 0; exp_err = 0; exp_blk = 0; n_acc = 0; n_hs = 0;
        drive(0, 0, 0, 1);
        chk("t6_stage_valid", stage_valid, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_out_idx", out_idx, 0);
        chk("t6_out_sob", out_sob, 0);
        chk("t6_flush_done", flush_done, 0);
        adv();
        for (int i = 0; i < 8; i++) step(1, i == 0, 0, 1);
        idle(12);

        chk("q_empty", sob_q.size(), 0);
        chk("acc_vs_hs", n_hs, n_acc);
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dct_pipe_ctrl.md
Name: dct_pipe_ctrl

Overview:
Sequencer for the ce-gated delay-register chain in the DCT datapath. It owns the single ce that advances every delay stage. It tracks which stages hold valid samples and applies valid/ready backpressure on both sides. It checks 8x8 block framing (64 samples) and supports flushing the pipe. It sits between the pixel source and the DCT output consumer and drives ce into all delay instances of one pipeline.

Parameters:
PIPE_DEPTH, 8, number of ce-gated delay stages sequenced (>=2)
BLK_SIZE, 64, samples per block
IDX_W, 6, width of the sample-index counters (log2 BLK_SIZE)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  source offers a sample
in_sob  in  1  offered sample is block sample 0
in_ready  out  1  controller accepts the sample this cycle
flush  in  1  request to drain the pipe (level, sampled each cycle)
ce  out  1  clock enable to every delay stage
stage_valid  out  PIPE_DEPTH  occupancy of each stage; bit 0 = first stage
out_valid  out  1  last stage holds a valid sample (= stage_valid[PIPE_DEPTH-1])
out_ready  in  1  consumer takes the output sample
out_idx  out  IDX_W  index within the block of the output sample
out_sob  out  1  output sample is index 0
out_eob  out  1  output sample is index BLK_SIZE-1
blk_done  out  1  one-cycle pulse after the handshake of index BLK_SIZE-1
err_sync  out  1  one-cycle pulse on a framing violation at input
flush_done  out  1  one-cycle pulse when the drain completes
busy  out  1  state != IDLE

Behaviour:
- Reset: rst=1 at a clock edge clears stage_valid, the sob shadow chain, in_cnt, out_cnt, blk_done, err_sync and flush_done. State is set to IDLE. ce and in_ready are forced to 0 while rst=1.
- Advance: ce = !rst & (!out_valid | out_ready). This is a fully stalling pipe, and ce is combinational from out_ready.
- in_ready = ce & (state != DRAIN) & !flush. accept = in_valid & in_ready.
- On ce: stage_valid shifts up one, and stage_valid[0] <= accept, so a bubble enters when there is no accept. A parallel sob shadow chain shifts identically, and its entry is in_sob & accept. With ce=0 both chains hold.
- Latency: a sample accepted at edge t gives out_valid=1 in cycle t+PIPE_DEPTH, when there are no stalls. Each stall cycle adds one.
- Input framing, on accept:
  - in_sob=1 with in_cnt!=0: err_sync pulse, and in_cnt <= 1 (the sample is treated as index 0).
  - in_sob=0 with in_cnt==0: err_sync pulse, and in_cnt still advances.
  - Otherwise: in_cnt <= (in_cnt+1) mod BLK_SIZE.
- Output index:
  - out_sob = out_valid & sob shadow tail.
  - out_idx = out_sob ? 0 : out_cnt.
  - out_eob = out_valid & (out_idx == BLK_SIZE-1).
  - On handshake (out_valid & out_ready): out_cnt <= (out_idx+1) mod BLK_SIZE.
  - blk_done is registered high for the cycle after an out_eob handshake.
- FSM:
  - IDLE: accept -> RUN; flush -> DRAIN.
  - RUN: flush -> DRAIN; otherwise stage_valid==0 & !accept -> IDLE.
  - DRAIN: no accepts; the pipe advances per ce. When stage_valid==0 at an edge: flush_done pulse next cycle, in_cnt <= 0, out_cnt <= 0, state -> IDLE (flush still high re-enters DRAIN).
  - Flush with an empty pipe: one DRAIN cycle, then flush_done.
- Simultaneous events:
  - accept and an output handshake in the same cycle are both honoured.
  - flush in the same cycle as a would-be accept: no accept, because in_ready is already low.
  - rst in DRAIN aborts the drain with no flush_done.
- Stall: with out_ready=0 and out_valid=1, ce=0, every stage holds, and in_ready=0.
- Counter wrap: BLK_SIZE-1 -> 0 on both counters.

Decomposition:
- Shared package dct_pkg: BLK_SIZE, IDX_W, and an enumerated FSM state type {IDLE, RUN, DRAIN}.
- Sub-module dct_occ_shift: a PIPE_DEPTH-bit ce-gated shift register with synchronous reset. It is instantiated twice, once for stage_valid and once for the sob shadow chain.
- Counters, FSM and pulse logic stay in the top level.

Test Plan:
1. Basic stream: PIPE_DEPTH=8, 64 back-to-back samples, in_sob on the first, out_ready=1.
   -> first out_valid 8 cycles after the first accept; out_idx runs 0..63; out_sob at 0; out_eob at 63; blk_done one cycle after; err_sync never.
2. Backpressure: out_ready=0 for 5 cycles while out_valid=1 mid-block.
   -> ce=0 and in_ready=0 for those 5 cycles; stage_valid unchanged; no sample lost or duplicated; out_idx sequence stays contiguous.
3. Framing error: in_sob asserted at input index 10.
   -> err_sync pulse; that sample exits with out_idx=0 and out_sob=1; the next block count restarts 1,2,...
4. Bubbles: in_valid toggling 1,0,1,0 for 8 samples.
   -> stage_valid shows the alternating pattern; out_valid alternates accordingly; out_idx 0..7 with no gaps.
5. Flush: flush for 1 cycle with 3 valid samples in the pipe, out_ready=1.
   -> in_ready=0 during DRAIN; 3 samples delivered; flush_done pulse; busy=0; the next block starts at in_cnt=0.
6. Reset mid-block at sample 30, then restart.
   -> all outputs 0 in the cycle after rst; state IDLE; a new block flows with out_idx from 0.
